// File: rtl/weight_spi_loader.sv
// rtl/weight_spi_loader.sv - SPI slave that streams weight bytes into a memory write port.
// Frame: 0xA5 command, address high, address low, then data bytes written to consecutive addresses.
module weight_spi_loader #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_WEIGHTS   = 10422
) (
    input  logic                     WLoad_Clock_In_Data,
    input  logic                     WLoad_Reset_InHigh,
    input  logic                     WLoad_SCLK_In,
    input  logic                     WLoad_CSn_In,
    input  logic                     WLoad_MOSI_In,
    output logic [ADDRESS_WIDTH-1:0] WLoad_Addr_Out_DataBUS,
    output logic [DATAWIDTH_BUS-1:0] WLoad_Data_Out_DataBUS,
    output logic                     WLoad_Load_OutLow,
    output logic                     WLoad_Busy_Out,
    output logic                     WLoad_Done_Out,
    output logic                     WLoad_Error_Out,
    output logic [ADDRESS_WIDTH-1:0] WLoad_Count_Out_DataBUS
);

    localparam int                     BCW      = $clog2(DATAWIDTH_BUS);
    localparam logic [BCW-1:0]         BIT_LAST = BCW'(DATAWIDTH_BUS - 1);
    localparam logic [BCW-1:0]         BIT_ONE  = BCW'(1);
    localparam logic [ADDRESS_WIDTH-1:0] A_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] A_LIMIT = ADDRESS_WIDTH'(NUM_WEIGHTS);
    localparam logic [7:0]             CMD_LOAD = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_H  = 3'd2,
        ADDR_L  = 3'd3,
        DATA    = 3'd4,
        DISCARD = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [1:0]               r_sclk_sync, r_csn_sync, r_mosi_sync;
    logic                     r_sclk_d, r_csn_d;
    logic [1:0]               r_settle;
    logic                     r_armed;
    logic [BCW-1:0]           r_bitcnt;
    logic [DATAWIDTH_BUS-1:0] r_shift;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_addr_out;
    logic [DATAWIDTH_BUS-1:0] r_data_out;
    logic [ADDRESS_WIDTH-1:0] r_count;
    logic                     r_load_n, r_done, r_error;

    logic                     w_sclk_s, w_csn_s, w_mosi_s;
    logic                     w_sclk_rise, w_csn_fall, w_csn_rise;
    logic                     w_byte_done;
    logic [DATAWIDTH_BUS-1:0] w_byte;
    logic                     w_write, w_err_set, w_load_h, w_load_l, w_done;

    assign w_sclk_s    = r_sclk_sync[1];
    assign w_csn_s     = r_csn_sync[1];
    assign w_mosi_s    = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_csn_rise  = w_csn_s & ~r_csn_d;
    // A fall only opens a frame once CS_n has been seen high after reset.
    assign w_csn_fall  = ~w_csn_s & r_csn_d & r_armed;
    assign w_byte      = {r_shift[DATAWIDTH_BUS-2:0], w_mosi_s};
    assign w_byte_done = w_sclk_rise && (r_state != IDLE) && (r_bitcnt == BIT_LAST) && !w_csn_rise;

    always_ff @(posedge WLoad_Clock_In_Data or posedge WLoad_Reset_InHigh) begin
        if (WLoad_Reset_InHigh) begin
            r_sclk_sync <= 2'b00;
            r_csn_sync  <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
            r_settle    <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], WLoad_SCLK_In};
            r_csn_sync  <= {r_csn_sync[0], WLoad_CSn_In};
            r_mosi_sync <= {r_mosi_sync[0], WLoad_MOSI_In};
            r_sclk_d    <= w_sclk_s;
            r_csn_d     <= w_csn_s;
            r_settle    <= {r_settle[0], 1'b1};
            r_armed     <= r_armed | (r_settle[1] & w_csn_s);
        end
    end

    always_ff @(posedge WLoad_Clock_In_Data or posedge WLoad_Reset_InHigh) begin
        if (WLoad_Reset_InHigh) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_write   = 1'b0;
        w_err_set = 1'b0;
        w_load_h  = 1'b0;
        w_load_l  = 1'b0;
        w_done    = 1'b0;
        if (w_csn_rise) begin
            w_next = IDLE;
            w_done = (r_state == DATA) && !r_error;
        end else if (w_csn_fall) begin
            w_next = CMD;
        end else if (w_byte_done) begin
            case (r_state)
                CMD: begin
                    if (w_byte[7:0] == CMD_LOAD) begin
                        w_next = ADDR_H;
                    end else begin
                        w_next    = DISCARD;
                        w_err_set = 1'b1;
                    end
                end
                ADDR_H: begin
                    w_next   = ADDR_L;
                    w_load_h = 1'b1;
                end
                ADDR_L: begin
                    w_next   = DATA;
                    w_load_l = 1'b1;
                end
                DATA: begin
                    if (r_addr < A_LIMIT) begin
                        w_write = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge WLoad_Clock_In_Data or posedge WLoad_Reset_InHigh) begin
        if (WLoad_Reset_InHigh) begin
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_count    <= '0;
            r_load_n   <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_load_n <= 1'b1;
            r_done   <= w_done;
            if (w_csn_fall) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
                r_addr   <= '0;
                r_count  <= '0;
                r_error  <= 1'b0;
            end else if (w_csn_rise) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_sclk_rise && (r_state != IDLE)) begin
                r_bitcnt <= (r_bitcnt == BIT_LAST) ? '0 : r_bitcnt + BIT_ONE;
                r_shift  <= w_byte;
            end
            if (w_load_h) begin
                r_addr[15:8] <= w_byte[7:0];
            end
            if (w_load_l) begin
                r_addr[7:0] <= w_byte[7:0];
            end
            if (w_write) begin
                r_addr_out <= r_addr;
                r_data_out <= w_byte;
                r_load_n   <= 1'b0;
                r_count    <= r_count + A_ONE;
                r_addr     <= r_addr + A_ONE;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign WLoad_Addr_Out_DataBUS  = r_addr_out;
    assign WLoad_Data_Out_DataBUS  = r_data_out;
    assign WLoad_Load_OutLow       = r_load_n;
    assign WLoad_Busy_Out          = ~w_csn_s;
    assign WLoad_Done_Out          = r_done;
    assign WLoad_Error_Out         = r_error;
    assign WLoad_Count_Out_DataBUS = r_count;

endmodule

// File: doc/weight_spi_loader.md
WEIGHT_SPI_LOADER -- requirements
Module: weight_spi_loader

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8: byte width of the SPI payload and of the write-data bus.
REQ-002 Parameter ADDRESS_WIDTH, default 16: width of the weight write address and the byte counter.
REQ-003 Parameter NUM_WEIGHTS, default 10422: number of valid weight locations (0..NUM_WEIGHTS-1).
REQ-004 WLoad_Clock_In_Data  in  1  system clock; the block uses one clock only.
REQ-005 WLoad_Reset_InHigh  in  1  asynchronous, active-high reset.
REQ-006 WLoad_SCLK_In  in  1  SPI clock, asynchronous to the system clock (mode 0).
REQ-007 WLoad_CSn_In  in  1  SPI chip select, active low, asynchronous.
REQ-008 WLoad_MOSI_In  in  1  SPI serial data, MSB first, asynchronous.
REQ-009 WLoad_Addr_Out_DataBUS  out  ADDRESS_WIDTH  weight write address.
REQ-010 WLoad_Data_Out_DataBUS  out  DATAWIDTH_BUS  weight write data.
REQ-011 WLoad_Load_OutLow  out  1  write strobe, active low, one clock per write.
REQ-012 WLoad_Busy_Out  out  1  high while a frame is open (synchronized CS_n low).
REQ-013 WLoad_Done_Out  out  1  one-clock pulse at the end of a valid data frame.
REQ-014 WLoad_Error_Out  out  1  frame error flag.
REQ-015 WLoad_Count_Out_DataBUS  out  ADDRESS_WIDTH  bytes written in the current or last frame.

Function
REQ-016 SCLK, CS_n and MOSI SHALL each pass through a 2-flop synchronizer; SCLK rising and CS_n falling/rising edges SHALL be detected from the synchronized values; MOSI SHALL be sampled on the detected SCLK rising edge.
REQ-017 The block SHALL support SCLK frequencies up to clk/4, with each SCLK high and low phase at least 2 clocks.
REQ-018 On a synchronized CS_n fall, the block SHALL clear the bit counter, Count and Error, and SHALL enter CMD.
REQ-019 The shift register SHALL assemble 8 bits MSB first; the 8th SCLK rise SHALL complete a byte, with the bit counter wrapping from 7 to 0.
REQ-020 FSM states: IDLE, CMD, ADDR_H, ADDR_L, DATA, DISCARD.
REQ-021 CMD: byte 0xA5 -> ADDR_H; any other byte -> DISCARD with Error set.
REQ-022 ADDR_H: the byte SHALL load address bits [15:8] -> ADDR_L. ADDR_L: the byte SHALL load address bits [7:0] -> DATA.
REQ-023 DATA, per completed byte with address < NUM_WEIGHTS: the block SHALL register Addr and Data, drive Load_OutLow low for exactly 1 clock, increment Count, and then increment the address.
REQ-024 Load_OutLow SHALL assert in the clock immediately after the 8th-edge detection; Addr and Data SHALL be valid in that clock and SHALL hold until the next write.
REQ-025 DATA, per completed byte with address >= NUM_WEIGHTS: the write SHALL be suppressed, Error set, and the FSM SHALL remain in DATA; the address SHALL not increment.
REQ-026 DISCARD SHALL ignore all bytes until CS_n rises.
REQ-027 On a synchronized CS_n rise from any state, the FSM SHALL go to IDLE and drop any partial byte. Done SHALL pulse for 1 clock only if the state was DATA and Error = 0.
REQ-028 If a CS_n rise coincides with the 8th-edge detection, CS_n SHALL win: the byte is dropped and no write occurs.
REQ-029 In IDLE, SCLK edges SHALL be ignored.
REQ-030 Busy SHALL equal the inverted synchronized CS_n.
REQ-031 Count SHALL never exceed NUM_WEIGHTS and SHALL hold its value after the frame ends.
REQ-032 The block SHALL never assert Load_OutLow twice in consecutive clocks.

Reset
REQ-033 On reset assertion, all state SHALL clear immediately, regardless of any frame in progress: FSM = IDLE, Load_OutLow = 1, Addr = 0, Data = 0, Busy = 0, Done = 0, Error = 0, Count = 0, shift and bit counters = 0, CS_n synchronizer = 1, SCLK synchronizer = 0.
REQ-034 After reset release during CS_n low, the block SHALL wait for a fresh CS_n fall before accepting data.

Verification
REQ-035 Frame A5 00 10 11 22 33, SCLK = clk/8 -> three Load_OutLow pulses at Addr 0x0010/0x0011/0x0012 with Data 0x11/0x22/0x33; Count = 3; Done pulses once; Error = 0.
REQ-036 Frame 3C 00 00 55 -> no writes; Error = 1; no Done; Count = 0.
REQ-037 Frame A5 28 B5 AA BB CC (start at 10421) -> one write at 10421 with Data 0xAA; Error = 1; Count = 1; no Done.
REQ-038 Frame A5 00 00 77 followed by 5 extra bits, then CS_n rise -> exactly one write (0x0000, 0x77); the partial byte is dropped; Done pulses.
REQ-039 Reset pulse asserted mid-DATA, then a new frame A5 00 05 99 -> all outputs at reset values immediately; then one write at 0x0005 with Data 0x99 and Count = 1.
REQ-040 Back-to-back frames separated by 4 clocks of CS_n high -> Count and Error clear at the second CS_n fall; the second frame writes correctly.
